// File: rtl/hold_pkg.sv
// Shared constants and types for the hold-protocol frame monitor.
package hold_pkg;

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned FCNT_W      = 16;
  localparam int unsigned EXP_LEN_DEF = 5;
  localparam int unsigned MIN_GAP_DEF = 2;
  localparam int unsigned ST_W        = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_ACTIVE = 2'd1;
  localparam logic [ST_W-1:0] ST_GAP    = 2'd2;

  typedef struct packed {
    logic len;
    logic tog;
    logic spur;
    logic gap;
  } err_t;

  // Increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/hold_edge.sv
// Input registers and rise/fall/toggle decode for the hold-protocol monitor.
module hold_edge
  import hold_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic g_in,
  input  logic f_in,
  output logic rise_c,
  output logic fall_c,
  output logic tog_c
);

  logic g_q;
  logic f_q;
  logic armed;

  // armed blocks a false rise when g_in is already high as reset releases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q   <= 1'b0;
      f_q   <= 1'b0;
      armed <= 1'b0;
    end else begin
      g_q <= g_in;
      f_q <= f_in;
      if (!g_in) armed <= 1'b1;
    end
  end

  assign rise_c = g_in & ~g_q & armed;
  assign fall_c = ~g_in & g_q;
  assign tog_c  = f_in ^ f_q;

endmodule

// File: rtl/hold_mon.sv
// Hold-protocol frame monitor: measures frame/gap lengths and keeps sticky error flags.
module hold_mon
  import hold_pkg::*;
#(
  parameter int unsigned EXP_LEN = EXP_LEN_DEF,
  parameter int unsigned MIN_GAP = MIN_GAP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              g_in,
  input  logic              f_in,
  input  logic              clr,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_len,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err_len,
  output logic              err_tog,
  output logic              err_spur,
  output logic              err_gap
);

  logic rise_c;
  logic fall_c;
  logic tog_c;

  hold_edge u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .g_in   (g_in),
    .f_in   (f_in),
    .rise_c (rise_c),
    .fall_c (fall_c),
    .tog_c  (tog_c)
  );

  logic [ST_W-1:0]   state,    state_nx;
  logic [CNT_W-1:0]  run_cnt,  run_nx;
  logic [CNT_W-1:0]  gap_cnt,  gap_nx;
  logic [CNT_W-1:0]  len_nx;
  logic [FCNT_W-1:0] cnt_nx;
  logic              done_nx;
  err_t              err,      err_nx;

  // Transition block: clr is applied first so any same-cycle set or frame end overrides it.
  always_comb begin
    state_nx = state;
    run_nx   = run_cnt;
    gap_nx   = gap_cnt;
    len_nx   = frame_len;
    cnt_nx   = clr ? '0 : frame_cnt;
    done_nx  = 1'b0;
    err_nx   = clr ? '0 : err;

    if (tog_c && !fall_c) err_nx.spur = 1'b1;

    case (state)
      ST_IDLE: begin
        if (rise_c) begin
          state_nx = ST_ACTIVE;
          run_nx   = CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (fall_c) begin
          state_nx = ST_GAP;
          len_nx   = run_cnt;
          done_nx  = 1'b1;
          cnt_nx   = cnt_nx + FCNT_W'(1);
          gap_nx   = CNT_W'(1);
          if (run_cnt != CNT_W'(EXP_LEN)) err_nx.len = 1'b1;
          if (!tog_c) err_nx.tog = 1'b1;
        end else if (g_in) begin
          run_nx = sat_inc(run_cnt);
        end
      end
      ST_GAP: begin
        if (rise_c) begin
          state_nx = ST_ACTIVE;
          run_nx   = CNT_W'(1);
          if (32'(gap_cnt) < MIN_GAP) err_nx.gap = 1'b1;
        end else if (!g_in) begin
          gap_nx = sat_inc(gap_cnt);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Registered state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      run_cnt    <= '0;
      gap_cnt    <= '0;
      frame_len  <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      err        <= '0;
    end else begin
      state      <= state_nx;
      run_cnt    <= run_nx;
      gap_cnt    <= gap_nx;
      frame_len  <= len_nx;
      frame_cnt  <= cnt_nx;
      frame_done <= done_nx;
      err        <= err_nx;
    end
  end

  assign err_len  = err.len;
  assign err_tog  = err.tog;
  assign err_spur = err.spur;
  assign err_gap  = err.gap;

endmodule
